// File: rtl/row_min_shift_pkg.sv
// Shared definitions for the row_min_shift block: FSM encoding and index sizing.
package row_min_shift_pkg;

   localparam logic [1:0] FILL  = 2'd0;
   localparam logic [1:0] CALC  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   typedef enum logic [1:0] {
      ST_FILL  = FILL,
      ST_CALC  = CALC,
      ST_DRAIN = DRAIN
   } state_t;

   // Beat index width; a row always has at least two elements.
   function automatic int idx_width(input int len);
      return (len < 2) ? 1 : $clog2(len);
   endfunction

endpackage

// File: rtl/row_min_shift_if.sv
// Stream bundle for row_min_shift: input stream, normalised output stream and row minimum.
interface row_min_shift_if #(
   parameter int DATA_WIDTH = 16
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic [DATA_WIDTH-1:0] row_min;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, row_min
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, row_min
   );

endinterface

// File: rtl/row_min_shift_min.sv
// Packed-vector minimum: unsigned compare across DATA_LENGTH elements, element 0 in the LSBs.
module row_min_shift_min #(
   parameter int DATA_WIDTH  = 16,
   parameter int DATA_LENGTH = 8
) (
   input  logic [DATA_WIDTH*DATA_LENGTH-1:0] data,
   output logic [DATA_WIDTH-1:0]             min_out
);

   always_comb begin
      min_out = data[DATA_WIDTH-1:0];
      for (int i = 1; i < DATA_LENGTH; i++) begin
         if (data[i*DATA_WIDTH +: DATA_WIDTH] < min_out)
            min_out = data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: rtl/row_min_shift.sv
// Row min-normalisation: buffer a row, take its minimum, replay each element minus that minimum.
// Optional macro ROW_MIN_SHIFT_ROWCNT_EN adds a 16-bit completed-row counter output.
module row_min_shift
   import row_min_shift_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int DATA_LENGTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   row_min_shift_if.slave    bus
`ifdef ROW_MIN_SHIFT_ROWCNT_EN
   ,
   output logic [15:0]       row_count
`endif
);

   localparam int                IDX_W = idx_width(DATA_LENGTH);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DATA_LENGTH - 1);

   state_t                                 state, state_nxt;
   logic [IDX_W-1:0]                       idx, idx_nxt;
   logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] row_buf;
   logic [DATA_WIDTH-1:0]                  min_val;
   logic [DATA_WIDTH-1:0]                  row_min_q;
   logic                                   alive;
   logic                                   wr_en;
   logic                                   load_min;

   row_min_shift_min #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DATA_LENGTH (DATA_LENGTH)
   ) u_min (
      .data    (row_buf),
      .min_out (min_val)
   );

   // alive keeps in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FILL;
         idx       <= '0;
         row_min_q <= '0;
         alive     <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         alive <= 1'b1;
         if (load_min)
            row_min_q <= min_val;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         row_buf[idx] <= bus.in_data;
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      wr_en         = 1'b0;
      load_min      = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = '0;
      case (state)
         ST_FILL: begin
            bus.in_ready = alive;
            if (bus.in_valid && alive) begin
               wr_en = 1'b1;
               if (idx == LAST) begin
                  idx_nxt   = '0;
                  state_nxt = ST_CALC;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         ST_CALC: begin
            load_min  = 1'b1;
            state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            bus.out_valid = 1'b1;
            // row_min never exceeds any buffered element, so this cannot wrap.
            bus.out_data  = row_buf[idx] - row_min_q;
            bus.out_last  = (idx == LAST);
            if (bus.out_ready) begin
               if (idx == LAST) begin
                  idx_nxt   = '0;
                  state_nxt = ST_FILL;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: begin
            idx_nxt   = '0;
            state_nxt = ST_FILL;
         end
      endcase
   end

   assign bus.row_min = row_min_q;

`ifdef ROW_MIN_SHIFT_ROWCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         row_count <= '0;
      else if (bus.out_valid && bus.out_ready && bus.out_last)
         row_count <= row_count + 16'd1;
   end
`endif

endmodule
